rv_fetch_unit: RTL and testbench
================================

Name: rv_fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction decoder/control unit.
- Holds the PC and issues one-outstanding-request reads to instruction memory over a req/ready/rvalid handshake.
- Presents a stable 32-bit instruction with a valid flag and advances the PC when the core retires it.
- Next-PC selection uses the decoder's j/bra/bne outputs plus the ALU zero flag.

Parameters:
XLEN, 64, PC/address width (RV64 datapath).
RESET_PC, 64'h0, PC loaded on reset.

Ports:
clk  input  1  core clock; all state on rising edge.
rst  input  1  asynchronous, active-high reset.
imem_req  output  1  instruction read request; held until accepted.
imem_addr  output  XLEN  read address, equals pc while imem_req=1.
imem_ready  input  1  memory accepts request this cycle.
imem_rvalid  input  1  read data valid.
imem_rdata  input  32  instruction word.
inst  output  32  instruction to decoder; stable while inst_valid=1.
inst_valid  output  1  inst is a fetched, unretired instruction.
pc  output  XLEN  address of inst.
pc_plus4  output  XLEN  pc+4, for JAL/JALR link writeback.
retire  input  1  core finished inst; sampled only when inst_valid=1.
j  input  1  decoder jump (JAL/JALR).
bra  input  1  decoder conditional branch.
bne  input  1  branch is BNE (else BEQ).
alu_zero  input  1  ALU compare result zero.
jump_target  input  XLEN  core-computed branch/jump target.
fault  output  1  sticky misaligned-target fault.
instret  output  XLEN  retired-instruction counter.

Behaviour:
- Reset (async, any state, including with a request outstanding):
  - state=IDLE, pc=RESET_PC, inst=32'h00000013 (NOP), inst_valid=0, imem_req=0, fault=0, instret=0.
  - Any response from a request issued before reset is discarded.
- States: IDLE, REQ, WAIT, HOLD, FAULT.
  - IDLE: next cycle -> REQ.
  - REQ: imem_req=1, imem_addr=pc. When imem_ready=1 -> WAIT. imem_rvalid in REQ is stale and ignored.
  - WAIT: imem_req=0. When imem_rvalid=1, capture inst=imem_rdata and -> HOLD (inst_valid=1 the cycle after rvalid).
  - HOLD: inst_valid=1; inst and pc held.
    - On retire=1: next_pc computed, instret+=1, inst_valid drops next cycle.
    - If next_pc[1:0]!=0: -> FAULT; else pc=next_pc and -> REQ.
  - FAULT: inst_valid=0, imem_req=0, fault=1. Leaves only by reset.
- next_pc (evaluated only at retire):
  - taken = j | (bra & (bne ? ~alu_zero : alu_zero)).
  - next_pc = taken ? jump_target : pc+4.
  - j has priority if j and bra are both set.
- Arithmetic:
  - pc+4 and instret wrap modulo 2^XLEN, no saturation.
  - pc_plus4 is combinational from pc.
- Boundaries:
  - retire outside HOLD is ignored.
  - imem_rvalid in IDLE/REQ/HOLD/FAULT is ignored.
  - imem_ready and imem_rvalid in the same REQ cycle: only ready is honoured; data must arrive at or after the next cycle.
  - Minimum fetch-to-valid latency: REQ (1 cycle, if ready) + WAIT (1 cycle, if rvalid) -> HOLD on the 3rd cycle.
  - pc wrap from 2^XLEN-4 to 0 is legal.

Decomposition:
- Shared package rv_core_pkg:
  - fetch state enum.
  - NOP_INST constant (32'h00000013).
  - opcode/funct3 constants shared with the decoder.
  - XLEN default.
- One sub-module, rv_next_pc: combinational taken/next_pc/misalign logic, reusable by a later pipelined fetch.

Test Plan:
- Reset: assert rst mid-WAIT, then release with imem_ready=1 and rvalid latency 1.
  -> first imem_addr=0x0, inst_valid=1 on cycle 3 with inst=imem_rdata. Stale rvalid during reset ignored. inst=0x00000013 and instret=0 while in reset.
- Sequential: retire 4 instructions with no branches and imem_ready delayed 2 cycles.
  -> imem_addr sequence 0x0, 0x4, 0x8, 0xC; instret=4; imem_req held through the ready stall.
- BEQ: pc=0x10, bra=1, bne=0.
  - alu_zero=1, jump_target=0x40, retire -> next imem_addr=0x40.
  - Repeat with alu_zero=0 -> 0x14.
- BNE and JAL: bne=1, alu_zero=0, target 0x80 -> 0x80. j=1 and bra=1 together with target 0x200 -> 0x200; pc_plus4=pc+4 while HOLD.
- Fault: retire with j=1, jump_target=0x102 -> fault=1, imem_req stays 0 for 20 cycles; rst clears fault and fetch restarts at RESET_PC.
- Protocol: retire asserted in WAIT, and imem_rvalid asserted in HOLD with a different word -> no PC change, inst unchanged, instret unchanged.

Source files
------------

// File: rtl/rv_core_pkg.sv
// rv_core_pkg: definitions shared by the fetch stage and the decoder.
//   - XLEN_DEFAULT : datapath/address width of the RV64 core
//   - NOP_INST     : canonical NOP (addi x0, x0, 0) shown while no instruction is held
//   - fetch_state_t: fetch FSM state encoding, also exported for debug
//   - opcode/funct3 constants for the control-flow instructions the fetch stage reacts to
package rv_core_pkg;

    localparam int XLEN_DEFAULT = 64;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/rv_next_pc.sv
// rv_next_pc: combinational next-PC selection.
//   Inputs : pc, j, bra, bne, alu_zero, jump_target
//   Outputs: pc_plus4 (pc+4, wraps), taken, next_pc, misaligned (next_pc not word aligned)
// A jump always wins over the branch condition; BNE inverts the ALU zero test.
module rv_next_pc
    import rv_core_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] pc,
    input  logic            j,
    input  logic            bra,
    input  logic            bne,
    input  logic            alu_zero,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] pc_plus4,
    output logic            taken,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    logic branch_cond;

    always_comb begin
        pc_plus4    = pc + XLEN'(4);
        branch_cond = bne ? ~alu_zero : alu_zero;
        taken       = j | (bra & branch_cond);
        next_pc     = taken ? jump_target : pc_plus4;
        misaligned  = |next_pc[1:0];
    end

endmodule

// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit: instruction-fetch stage feeding the decoder.
//   Memory side : imem_req/imem_addr out, imem_ready/imem_rvalid/imem_rdata in
//   Decoder side: inst, inst_valid, pc, pc_plus4 out; retire, j, bra, bne,
//                 alu_zero, jump_target in
//   Status      : fault (sticky misaligned target), instret, state (FSM debug)
//
// Handshake: imem_req stays high with imem_addr=pc until a cycle where
// imem_ready=1 (request accepted); exactly one request is outstanding and its
// data is taken on the first imem_rvalid=1 seen while waiting. rvalid outside
// the waiting state (including the accept cycle itself) is ignored. On the
// decoder side inst/pc are stable while inst_valid=1 and retire is only
// honoured while inst_valid=1.
module rv_fetch_unit
    import rv_core_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     inst,
    output logic            inst_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            retire,
    input  logic            j,
    input  logic            bra,
    input  logic            bne,
    input  logic            alu_zero,
    input  logic [XLEN-1:0] jump_target,
    output logic            fault,
    output logic [XLEN-1:0] instret,
    output fetch_state_t    state
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     inst_q;
    logic [XLEN-1:0] instret_q;
    logic [XLEN-1:0] next_pc;
    logic            taken;
    logic            misaligned;
    logic            do_retire;

    rv_next_pc #(.XLEN(XLEN)) u_next_pc (
        .pc          (pc_q),
        .j           (j),
        .bra         (bra),
        .bne         (bne),
        .alu_zero    (alu_zero),
        .jump_target (jump_target),
        .pc_plus4    (pc_plus4),
        .taken       (taken),
        .next_pc     (next_pc),
        .misaligned  (misaligned)
    );

    assign do_retire = (state_q == S_HOLD) && retire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= NOP_INST;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_WAIT && imem_rvalid) begin
                inst_q <= imem_rdata;
            end
            if (do_retire) begin
                instret_q <= instret_q + XLEN'(1);
                // On a misaligned target the pc keeps the faulting instruction's address.
                if (!misaligned) begin
                    pc_q <= next_pc;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        fault      = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) state_d = S_HOLD;
            end
            S_HOLD: begin
                inst_valid = 1'b1;
                if (retire) state_d = misaligned ? S_FAULT : S_REQ;
            end
            S_FAULT: fault = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_addr = pc_q;
    assign inst      = inst_q;
    assign pc        = pc_q;
    assign instret   = instret_q;
    assign state     = state_q;

endmodule

// File: tb/tb_rv_fetch_unit.sv
// tb_rv_fetch_unit: directed + randomized bench for rv_fetch_unit. The bench
// plays instruction memory and the core; a reference model of pc, instret and
// the fault flag is kept in plain variables and expected request addresses go
// through exp_q.
module tb_rv_fetch_unit;
    import rv_core_pkg::*;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready = 1'b0;
    logic            imem_rvalid = 1'b0;
    logic [31:0]     imem_rdata = 32'h0;
    logic [31:0]     inst;
    logic            inst_valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            retire = 1'b0;
    logic            j = 1'b0;
    logic            bra = 1'b0;
    logic            bne = 1'b0;
    logic            alu_zero = 1'b0;
    logic [XLEN-1:0] jump_target = '0;
    logic            fault;
    logic [XLEN-1:0] instret;
    fetch_state_t    dbg_state;

    rv_fetch_unit #(.XLEN(XLEN), .RESET_PC(64'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .retire      (retire),
        .j           (j),
        .bra         (bra),
        .bne         (bne),
        .alu_zero    (alu_zero),
        .jump_target (jump_target),
        .fault       (fault),
        .instret     (instret),
        .state       (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // reference model and scoreboard
    logic [XLEN-1:0] m_pc;
    logic [XLEN-1:0] m_instret;
    logic            m_fault;
    logic [31:0]     m_inst;
    logic [XLEN-1:0] exp_q[$];
    int              n_cmp = 0;
    int              n_err = 0;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = 64'h0;
        m_instret = '0;
        m_fault   = 1'b0;
        m_inst    = 32'h0000_0013;
        exp_q.delete();
        exp_q.push_back(64'h0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},     imem_req, 0);
        check({tag, "_inst"},    inst, 64'h13);
        check({tag, "_valid"},   inst_valid, 0);
        check({tag, "_instret"}, instret, 0);
        check({tag, "_fault"},   fault, 0);
        check({tag, "_pc"},      pc, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_values("rst_async");
        @(negedge clk);
        check_reset_values("rst_held");
        rst = 1'b0;
        model_reset();
    endtask

    // Memory driver: waits for a request, stalls ready rdly cycles, then
    // returns word vdly cycles after the WAIT cycle begins. Stale rvalid and
    // retire pulses are sprinkled where they must be ignored.
    task automatic serve(input int rdly, input int vdly, input logic [31:0] word);
        int n;
        logic [XLEN-1:0] ea;
        n = 0;
        while (imem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", imem_req, 1);
        ea = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        check("imem_addr", imem_addr, ea);
        check("valid_in_req", inst_valid, 0);
        for (int i = 0; i < rdly; i++) begin
            imem_ready  = 1'b0;
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = ~word;
            retire      = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("req_held", imem_req, 1);
            check("addr_held", imem_addr, ea);
        end
        imem_ready  = 1'b1;
        imem_rvalid = 1'($urandom_range(0, 1));
        imem_rdata  = ~word;
        @(negedge clk);
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        for (int i = 0; i < vdly; i++) begin
            retire = 1'($urandom_range(0, 1));
            check("req_in_wait", imem_req, 0);
            check("valid_in_wait", inst_valid, 0);
            @(negedge clk);
        end
        check("req_in_wait", imem_req, 0);
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        retire      = 1'($urandom_range(0, 1));
        @(negedge clk);
        imem_rvalid = 1'b0;
        retire      = 1'b0;
        m_inst      = word;
        check("valid_hold", inst_valid, 1);
        check("inst_hold", inst, word);
        check("pc_hold", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 64'd4);
        check("instret_hold", instret, m_instret);
        check("req_hold", imem_req, 0);
    endtask

    // Core driver: retires the held instruction with the given decode outputs.
    task automatic do_retire(input logic jj, input logic bb, input logic nn, input logic zz,
                             input logic [XLEN-1:0] tgt);
        logic [XLEN-1:0] nxt;
        if (jj)
            nxt = tgt;
        else if (bb && !nn && zz)
            nxt = tgt;
        else if (bb && nn && !zz)
            nxt = tgt;
        else
            nxt = m_pc + 64'd4;
        m_instret = m_instret + 64'd1;
        if (nxt % 4 != 0) begin
            m_fault = 1'b1;
        end else begin
            m_pc = nxt;
            exp_q.push_back(nxt);
        end
        retire = 1'b1; j = jj; bra = bb; bne = nn; alu_zero = zz; jump_target = tgt;
        @(negedge clk);
        retire = 1'b0;
        j = 1'($urandom_range(0, 1)); bra = 1'($urandom_range(0, 1));
        bne = 1'($urandom_range(0, 1)); alu_zero = 1'($urandom_range(0, 1));
        jump_target = {$urandom, $urandom};
        check("valid_after_retire", inst_valid, 0);
        check("instret", instret, m_instret);
        check("fault", fault, m_fault);
        check("pc_after_retire", pc, m_pc);
        check("req_after_retire", imem_req, !m_fault);
    endtask

    initial begin
        logic [XLEN-1:0] tgt;
        // reset state while rst is held from time zero
        model_reset();
        @(negedge clk);
        check_reset_values("por");
        @(negedge clk);
        rst = 1'b0;

        // first request accepted, then reset lands in WAIT with a response in flight
        n_cmp = n_cmp;
        begin
            int n;
            n = 0;
            while (imem_req !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("first_req", imem_req, 1);
            check("first_addr", imem_addr, 0);
            imem_ready = 1'b1;
            @(negedge clk);
            imem_ready  = 1'b0;
            rst         = 1'b1;
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hBADC_0DE5;
            #1;
            check_reset_values("rst_mid_wait");
            @(negedge clk);
            check_reset_values("rst_stale_rvalid");
            rst = 1'b0;
            model_reset();
            @(negedge clk);
            imem_rvalid = 1'b0;
            check("stale_after_rst", inst_valid, 0);
        end

        // minimum latency fetch from RESET_PC
        serve(0, 0, 32'h0010_0093);
        do_retire(0, 0, 0, 0, 64'h0);

        // sequential run with ready stalled 2 cycles
        serve(2, 0, 32'h0020_0113);
        do_retire(0, 0, 0, 0, 64'h0);
        serve(2, 0, 32'h0030_0193);
        do_retire(0, 0, 0, 0, 64'h0);
        serve(2, 0, 32'h0040_0213);
        do_retire(0, 0, 0, 0, 64'h0);
        check("instret_four", instret, 64'd4);

        // BEQ taken at 0x10
        serve(0, 1, 32'h0000_0463);
        check("beq_pc", pc, 64'h10);
        do_retire(0, 1, 0, 1, 64'h40);
        // jump back to 0x10, BEQ not taken
        serve(1, 0, 32'h0000_006F);
        do_retire(1, 0, 0, 0, 64'h10);
        serve(0, 0, 32'h0000_0463);
        do_retire(0, 1, 0, 0, 64'h40);
        // BNE taken / not taken, then j and bra together
        serve(0, 2, 32'h0000_1463);
        do_retire(0, 1, 1, 0, 64'h80);
        serve(1, 1, 32'h0000_1463);
        do_retire(0, 1, 1, 1, 64'h300);
        serve(0, 0, 32'h0000_006F);
        do_retire(1, 1, 0, 0, 64'h200);

        // randomized decode outputs with aligned targets
        for (int k = 0; k < 12; k++) begin
            serve($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            tgt = {$urandom, $urandom} & ~64'h3;
            do_retire(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tgt);
        end

        // pc wrap from 2^64-4 to 0
        serve(0, 0, 32'h0000_0013);
        do_retire(1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC);
        serve(0, 0, 32'h0000_0013);
        check("wrap_plus4", pc_plus4, 64'h0);
        do_retire(0, 0, 0, 0, 64'h0);
        serve(0, 0, 32'h1234_5013);

        // rvalid with a different word while holding is ignored
        for (int k = 0; k < 3; k++) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hFEED_BEEF;
            @(negedge clk);
            check("hold_inst", inst, m_inst);
            check("hold_pc", pc, m_pc);
            check("hold_instret", instret, m_instret);
            check("hold_valid", inst_valid, 1);
        end
        imem_rvalid = 1'b0;

        // misaligned jump target -> sticky fault
        do_retire(1, 0, 0, 0, 64'h102);
        for (int k = 0; k < 20; k++) begin
            imem_ready  = 1'($urandom_range(0, 1));
            imem_rvalid = 1'($urandom_range(0, 1));
            retire      = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("fault_req", imem_req, 0);
            check("fault_flag", fault, 1);
            check("fault_valid", inst_valid, 0);
            check("fault_instret", instret, m_instret);
        end
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        retire      = 1'b0;

        // reset clears the fault and fetch restarts at RESET_PC
        apply_reset();
        serve(0, 0, 32'h0050_0293);
        check("restart_fault", fault, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
